// File: rtl/mdu.sv
// MDU: multicycle multiply/divide unit with HI/LO registers.
// Optional macro MDU_MADD_EN enables MADD/MSUB (ops 6/7); otherwise they are no-ops.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic        r_busy, r_done;

  logic        w_is_mul, w_is_div, w_signed_mul;
  logic [15:0] w_lat;
  logic [63:0] w_a_ext, w_b_ext, w_prod, w_res;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag, w_quo, w_rem;

  // Decode the incoming op into latency classes.
  always_comb begin
    w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    w_is_mul = w_is_mul || (op == OP_MADD) || (op == OP_MSUB);
`endif
    w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    w_lat    = w_is_div ? 16'(DIV_CYCLES) : 16'(MULT_CYCLES);
  end

  // Result datapath from the captured operands; divide works on magnitudes so
  // 0x80000000 / -1 naturally wraps to 0x80000000 with remainder 0.
  always_comb begin
    w_signed_mul = (r_op == OP_MULT) || (r_op == OP_MADD) || (r_op == OP_MSUB);
    w_a_ext  = w_signed_mul ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    w_b_ext  = w_signed_mul ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    w_prod   = w_a_ext * w_b_ext;
    w_a_neg  = (r_op == OP_DIV) && r_a[31];
    w_b_neg  = (r_op == OP_DIV) && r_b[31];
    w_a_mag  = w_a_neg ? (32'd0 - r_a) : r_a;
    w_b_mag  = w_b_neg ? (32'd0 - r_b) : r_b;
    w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    w_q_mag  = w_a_mag / w_b_safe;
    w_r_mag  = w_a_mag % w_b_safe;
    w_quo    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
    w_res    = {r_hi, r_lo};
    case (r_op)
      OP_MULT, OP_MULTU: w_res = w_prod;
      OP_DIV, OP_DIVU:   if (r_b != 32'd0) w_res = {w_rem, w_quo};
`ifdef MDU_MADD_EN
      OP_MADD:           w_res = {r_hi, r_lo} + w_prod;
      OP_MSUB:           w_res = {r_hi, r_lo} - w_prod;
`endif
      default:           w_res = {r_hi, r_lo};
    endcase
  end

  // Controller: IDLE accepts ops, RUN counts down, FINISH commits hi/lo.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (op == OP_MTHI) begin
              r_hi <= a;
            end else if (op == OP_MTLO) begin
              r_lo <= a;
            end else if (w_is_mul || w_is_div) begin
              r_op    <= op;
              r_a     <= a;
              r_b     <= b;
              r_busy  <= 1'b1;
              r_cnt   <= w_lat - 16'd1;
              r_state <= (w_lat <= 16'd1) ? FINISH : RUN;
            end
          end
        end
        RUN: begin
          if (r_cnt <= 16'd1) begin
            r_state <= FINISH;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        FINISH: begin
          {r_hi, r_lo} <= w_res;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected results, a monitor checks at done.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk, reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: what an op does to {hi,lo}, and its busy length (0 = not a mult/div op).
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output int lat, output logic [63:0] res);
    int     sx, sy;
    longint lx, ly, p, q, r;
    sx = x; sy = y; lx = sx; ly = sy;
    res = {m_hi, m_lo};
    lat = 0;
    case (o)
      3'd0: begin lat = MC; p = lx * ly; res = p; end
      3'd1: begin lat = MC; res = {32'd0, x} * {32'd0, y}; end
      3'd2: begin
        lat = DC;
        if (y != 0) begin
          q = lx / ly; r = lx % ly;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin lat = DC; if (y != 0) res = {x % y, x / y}; end
      3'd4: res = {x, m_lo};
      3'd5: res = {m_hi, x};
`ifdef MDU_MADD_EN
      3'd6: begin lat = MC; p = lx * ly; res = {m_hi, m_lo} + p; end
      3'd7: begin lat = MC; p = lx * ly; res = {m_hi, m_lo} - p; end
`endif
      default: ;
    endcase
  endfunction

  // Caller is just after a negedge; returns just after the next negedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int          lat;
    logic [63:0] res;
    exp_t        e;
    model(o, x, y, lat, res);
    if (lat != 0) begin
      e.res = res; e.lat = lat;
      sb.push_back(e);
    end
    {m_hi, m_lo} = res;
    start = 1; op = o; a = x; b = y;
    @(negedge clk); #1;
    start = 0; op = 3'($urandom); a = $urandom; b = $urandom;
    if (lat == 0) begin
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("direct_hilo", {hi, lo}, {m_hi, m_lo});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DC; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk); #1;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Monitor: on each done pulse pop the expected result and check value and busy length.
  initial begin
    int   run_cnt;
    exp_t e;
    run_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run_cnt = 0;
      end else begin
        if (busy) run_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("sb_hilo", {hi, lo}, e.res);
            chk("sb_busy_len", 64'(run_cnt), 64'(e.lat));
            chk("done_busy_low", {63'd0, busy}, 64'd0);
          end
          run_cnt = 0;
        end
      end
    end
  end

  initial begin
    int k;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 0; start = 0; op = 0; a = 0; b = 0;
    repeat (3) @(negedge clk);
    // Start is held high during reset and must be ignored.
    start = 1; op = 3'd4; a = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
    start = 0;
    reset = 1;
    @(negedge clk); #1;

    issue(3'd0, 32'hFFFF_FFFE, 32'd3); drain();
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2); drain();
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'd3, 32'd7, 32'd2); drain();
    chk("divu", {hi, lo}, 64'h0000_0001_0000_0003);
    issue(3'd4, 32'h1234_5678, 32'd0);
    issue(3'd2, 32'd55, 32'd0); drain();
    chk("div_by_zero", {hi, lo}, 64'h1234_5678_0000_0003);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); drain();
    chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);

    // MTLO launched while MULTU is busy must be ignored.
    issue(3'd1, 32'h0001_0000, 32'h0003_0001);
    @(negedge clk); #1;
    start = 1; op = 3'd5; a = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    start = 0;
    drain();
    chk("mtlo_ignored", {hi, lo}, 64'h0000_0003_0001_0000);

    // Back-to-back: issue again immediately after done.
    issue(3'd0, 32'd6, 32'd7); drain();
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); drain();
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

`ifdef MDU_MADD_EN
    issue(3'd4, 32'd0, 32'd0);
    issue(3'd5, 32'd10, 32'd0);
    issue(3'd6, 32'd2, 32'd3); drain();
    chk("madd", {hi, lo}, 64'd16);
    issue(3'd7, 32'd4, 32'd5); drain();
    chk("msub", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFC);
`else
    issue(3'd6, 32'd2, 32'd3);
    issue(3'd7, 32'd4, 32'd5);
    repeat (MC + 2) @(negedge clk);
    #1;
    chk("madd_disabled_busy", {63'd0, busy}, 64'd0);
`endif

    // Reset in the third busy cycle of a DIV aborts it.
    issue(3'd2, 32'd100, 32'd7);
    @(negedge clk); #1;
    @(negedge clk); #1;
    reset = 0;
    #1;
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_busy_done", {62'd0, busy, done}, 64'd0);
    sb.delete();
    m_hi = 0; m_lo = 0;
    @(negedge clk); #1;
    reset = 1;
    k = 0;
    repeat (DC + 5) begin
      @(negedge clk); #1;
      if (busy || done) k++;
    end
    chk("abort_no_resume", 64'(k), 64'd0);
    chk("abort_hilo_after", {hi, lo}, 64'd0);

    // Randomized ops against the model.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 20); rb = 32'(-$urandom_range(1, 5)); end
        default: ;
      endcase
      issue(ro, ra, rb);
      drain();
      chk("rand_hilo", {hi, lo}, {m_hi, m_lo});
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
